// File: rtl/plab5_mcore_mem_req_net_injector.sv
// Purpose : wraps memory requests into network messages routed to a bank by address.
// Latency : 1 cycle through a 2-entry FIFO (no empty bypass); 1 message/cycle sustained.
// Backpressure: in_rdy drops when both entries are full, regardless of out_rdy.
//
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   in_val/in_rdy/in_msg    - memory request in {type, opaque, addr, len, data}
//   out_val/out_rdy/out_msg - network message out {dest, src, opaque, payload}
//   num_sent           - 16-bit wrapping count of network messages sent
module plab5_mcore_mem_req_net_injector #(
  parameter int p_net_src           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 2,
  localparam int c_len_nbits = $clog2(p_mem_data_nbits / 8),
  localparam int c_req_nbits = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                               + c_len_nbits + p_mem_data_nbits,
  localparam int c_net_nbits = c_req_nbits + p_net_opaque_nbits
                               + 2 * p_net_srcdest_nbits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [c_req_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [c_net_nbits-1:0] out_msg,
  output logic [15:0]            num_sent
);

  // Bit offsets of the request fields, LSB first: data, len, addr, opaque, type.
  localparam int c_len_lsb  = p_mem_data_nbits;
  localparam int c_addr_lsb = c_len_lsb + c_len_nbits;
  localparam int c_opq_lsb  = c_addr_lsb + p_mem_addr_nbits;
  // Low opaque bits kept from the original request; the top bits carry our source ID.
  localparam int c_opq_keep = p_mem_opaque_nbits - p_net_srcdest_nbits;

  localparam logic [p_net_srcdest_nbits-1:0] c_src = p_net_srcdest_nbits'(p_net_src);

  // FIFO state
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [15:0]            num_sent_q, num_sent_d;
  logic [c_req_nbits-1:0] entry_q [0:1];
  logic [c_req_nbits-1:0] entry_d [0:1];

  logic enq;
  logic deq;

  always_comb begin
    in_rdy  = !reset && (count_q != 2'd2);
    out_val = (count_q != 2'd0);
    enq     = in_val && in_rdy;
    deq     = out_val && out_rdy;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    num_sent_d = num_sent_q;
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];

    if (enq) begin
      entry_d[wr_ptr_q] = in_msg;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (deq) begin
      rd_ptr_d   = ~rd_ptr_q;
      num_sent_d = num_sent_q + 16'd1;
    end

    // Simultaneous enqueue and dequeue leaves the occupancy unchanged.
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      num_sent_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      num_sent_q <= num_sent_d;
    end
  end

  // Payload storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q[0] <= entry_d[0];
    entry_q[1] <= entry_d[1];
  end

  // Translation of the head entry into a network message.
  logic [c_req_nbits-1:0]         head;
  logic [c_req_nbits-1:0]         payload;
  logic [p_net_srcdest_nbits-1:0] dest;

  always_comb begin
    head    = entry_q[rd_ptr_q];
    payload = head;
    payload[c_opq_lsb +: p_mem_opaque_nbits] = {c_src, head[c_opq_lsb +: c_opq_keep]};
    // Banks are interleaved on 16-byte lines: address bits above the line offset pick the bank.
    dest    = head[c_addr_lsb + 4 +: p_net_srcdest_nbits];
    out_msg = {dest, c_src, {p_net_opaque_nbits{1'b0}}, payload};
  end

  assign num_sent = num_sent_q;

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_injector.sv
module tb_plab5_mcore_mem_req_net_injector;

  localparam int O   = 8;
  localparam int A   = 32;
  localparam int D   = 32;
  localparam int L   = 2;
  localparam int REQ = 3 + O + A + L + D;
  localparam int NET = REQ + 4 + 2 * 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_val;
  logic           in_rdy;
  logic [REQ-1:0] in_msg;
  logic           out_val;
  logic           out_rdy;
  logic [NET-1:0] out_msg;
  logic [15:0]    num_sent;

  plab5_mcore_mem_req_net_injector #(.p_net_src(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .num_sent (num_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [NET-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [REQ-1:0] mk_req(input logic [2:0] typ, input logic [7:0] opq,
                                            input logic [31:0] addr, input logic [1:0] len,
                                            input logic [31:0] data);
    return {typ, opq, addr, len, data};
  endfunction

  // Expected network message: hand-supplied dest and rewritten opaque, src=2, net opaque=0.
  function automatic logic [NET-1:0] mk_exp(input logic [REQ-1:0] req, input logic [1:0] dest,
                                            input logic [7:0] opq);
    logic [REQ-1:0] p;
    p = req;
    p[D+L+A +: O] = opq;
    return {dest, 2'd2, 4'd0, p};
  endfunction

  // Monitor: every handshake on the output pops and compares one expected message.
  initial begin
    logic [NET-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks = n_checks + 1;
          $display("FAIL unexpected_out: got %h expected no message", out_msg);
        end else begin
          e = exp_q.pop_front();
          chk("out_msg", 128'(out_msg), 128'(e));
        end
      end
    end
  end

  task automatic send(input logic [REQ-1:0] req, input logic [1:0] dest, input logic [7:0] opq);
    in_val = 1'b1;
    in_msg = req;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        exp_q.push_back(mk_exp(req, dest, opq));
        @(posedge clk); #1;
        in_val = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks = n_checks + 1;
    $display("FAIL send_timeout: got in_rdy=0 for 100 cycles expected acceptance");
    in_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_val) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_checks = n_checks + 1;
    $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_val", 128'(out_val), 128'(0));
    chk("rst_in_rdy", 128'(in_rdy), 128'(0));
    chk("rst_num_sent", 128'(num_sent), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", 128'(in_rdy), 128'(1));
    chk("post_rst_out_val", 128'(out_val), 128'(0));
    @(posedge clk); #1;

    // Single read: dest 2, opaque 0x01 -> 0x81
    out_rdy = 1'b1;
    send(mk_req(3'd0, 8'h01, 32'h0000_1024, 2'd1, 32'h0), 2'd2, 8'h81);
    chk("s1_out_val_latency", 128'(out_val), 128'(1));
    drain();
    chk("s1_num_sent", 128'(num_sent), 128'(1));

    // Writes with bank interleave on addr[5:4]
    send(mk_req(3'd1, 8'h05, 32'h0000_1070, 2'd0, 32'habcd_ef01), 2'd3, 8'h85);
    send(mk_req(3'd1, 8'h06, 32'h0000_1064, 2'd0, 32'habcd_ef01), 2'd2, 8'h86);
    send(mk_req(3'd1, 8'h07, 32'h0000_1068, 2'd0, 32'habcd_ef01), 2'd2, 8'h87);
    send(mk_req(3'd1, 8'h08, 32'h0000_10fc, 2'd0, 32'habcd_ef01), 2'd3, 8'h88);
    drain();
    chk("s2_num_sent", 128'(num_sent), 128'(5));

    // Full FIFO: third request blocked even once out_rdy rises
    out_rdy = 1'b0;
    send(mk_req(3'd0, 8'h3f, 32'h0000_2000, 2'd0, 32'h1111_1111), 2'd0, 8'hbf);
    send(mk_req(3'd0, 8'h40, 32'h0000_2010, 2'd0, 32'h2222_2222), 2'd1, 8'h80);
    in_val = 1'b1;
    in_msg = mk_req(3'd0, 8'hff, 32'h0000_2030, 2'd0, 32'h3333_3333);
    @(negedge clk);
    chk("s3_full_in_rdy", 128'(in_rdy), 128'(0));
    chk("s3_full_out_val", 128'(out_val), 128'(1));
    @(posedge clk); #1;
    out_rdy = 1'b1;
    #1;
    chk("s3_full_in_rdy_out_rdy", 128'(in_rdy), 128'(0));
    send(mk_req(3'd0, 8'hff, 32'h0000_2030, 2'd0, 32'h3333_3333), 2'd3, 8'hbf);
    drain();
    chk("s3_in_rdy_back", 128'(in_rdy), 128'(1));
    chk("s3_num_sent", 128'(num_sent), 128'(8));

    // Steady state with one entry: enqueue and dequeue every cycle
    out_rdy = 1'b0;
    send(mk_req(3'd1, 8'h00, 32'h0000_3000, 2'd0, 32'h0), 2'd0, 8'h80);
    out_rdy = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      send(mk_req(3'd1, 8'(k), 32'h0000_3000 + 32'(k * 16), 2'd0, 32'(k)),
           2'(k), 8'h80 | 8'(k));
    end
    chk("s4_cycles", 128'(cyc - t0), 128'(10));
    chk("s4_num_sent", 128'(num_sent), 128'(18));
    chk("s4_out_val", 128'(out_val), 128'(1));
    chk("s4_in_rdy", 128'(in_rdy), 128'(1));
    drain();
    chk("s4_num_sent_drained", 128'(num_sent), 128'(19));

    // Asynchronous reset with a full FIFO
    out_rdy = 1'b0;
    send(mk_req(3'd0, 8'h11, 32'h0000_4000, 2'd0, 32'h0), 2'd0, 8'h91);
    send(mk_req(3'd0, 8'h12, 32'h0000_4010, 2'd0, 32'h0), 2'd1, 8'h92);
    #3;
    reset = 1'b1;
    #1;
    chk("s5_async_out_val", 128'(out_val), 128'(0));
    chk("s5_async_in_rdy", 128'(in_rdy), 128'(0));
    chk("s5_async_num_sent", 128'(num_sent), 128'(0));
    exp_q.delete();
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("s5_post_in_rdy", 128'(in_rdy), 128'(1));
    chk("s5_post_out_val", 128'(out_val), 128'(0));
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("s5_discarded", 128'(out_val), 128'(0));
    chk("s5_num_sent", 128'(num_sent), 128'(0));
    @(posedge clk); #1;

    // Counter wrap
    for (int i = 0; i < 65535; i++) begin
      send(mk_req(3'd1, 8'(i), 32'(i) << 4, 2'd0, 32'(i)), 2'(i), {2'b10, 6'(i)});
    end
    drain();
    chk("s6_num_sent_ffff", 128'(num_sent), 128'(16'hffff));
    send(mk_req(3'd0, 8'h2a, 32'h0000_5020, 2'd3, 32'hdead_beef), 2'd2, 8'haa);
    drain();
    chk("s6_num_sent_wrap", 128'(num_sent), 128'(0));

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
